// File: rtl/and4_sweep_pkg.sv
// rtl/and4_sweep_pkg.sv - shared state encoding and default parameters for the AND-tree sweep checker
package and4_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_SETTLE = 1;
  localparam int DEF_ERR_W  = 8;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - clearable up-counter that sticks at its maximum value
module sat_counter #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [ERR_W-1:0] count
);

  logic [ERR_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && !(&r_count)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/and4_sweep_checker.sv
// rtl/and4_sweep_checker.sv - exhaustive clocked sweep of an AND tree with mismatch count and first-error capture
module and4_sweep_checker
  import and4_sweep_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SETTLE = DEF_SETTLE,
  parameter int ERR_W  = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] dut_data,
  input  logic             dut_result,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_vec
);

  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE);

  state_t           r_state;
  state_t           w_next;
  logic [SW-1:0]    r_settle;
  logic [WIDTH-1:0] r_data;
  logic             r_pass;
  logic             r_fev_valid;
  logic [WIDTH-1:0] r_fev;
  logic [ERR_W-1:0] w_err;

  logic w_all_ones;
  logic w_accept;
  logic w_mismatch;

  // the expected AND reduction is 1 only on the terminal all-ones vector
  assign w_all_ones = &r_data;
  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_mismatch = (r_state == ST_CHECK) && (dut_result != w_all_ones);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
      ST_SETTLE: if (r_settle == SW'(1)) w_next = ST_CHECK;
      ST_CHECK: begin
        if (w_all_ones)       w_next = ST_DONE;
        else if (SETTLE == 0) w_next = ST_CHECK;
        else                  w_next = ST_SETTLE;
      end
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle    <= '0;
      r_data      <= '0;
      r_pass      <= 1'b0;
      r_fev_valid <= 1'b0;
      r_fev       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_settle    <= SETTLE_LD;
            r_data      <= '0;
            r_pass      <= 1'b0;
            r_fev_valid <= 1'b0;
            r_fev       <= '0;
          end
        end
        ST_SETTLE: r_settle <= r_settle - 1'b1;
        ST_CHECK: begin
          if (w_mismatch && !r_fev_valid) begin
            r_fev_valid <= 1'b1;
            r_fev       <= r_data;
          end
          // all-ones is held after the sweep until the next start
          if (!w_all_ones) begin
            r_data   <= r_data + 1'b1;
            r_settle <= SETTLE_LD;
          end
        end
        ST_DONE:   r_pass <= (w_err == '0);
        default:   ;
      endcase
    end
  end

  sat_counter #(
    .ERR_W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_accept),
    .inc   (w_mismatch),
    .count (w_err)
  );

  assign dut_data        = r_data;
  assign busy            = (r_state == ST_SETTLE) || (r_state == ST_CHECK);
  assign done            = (r_state == ST_DONE);
  assign pass            = r_pass;
  assign err_count       = w_err;
  assign first_err_valid = r_fev_valid;
  assign first_err_vec   = r_fev;

endmodule

// File: tb/tb_and4_sweep_checker.sv
// tb/tb_and4_sweep_checker.sv - scoreboard bench for the AND-tree sweep checker
module tb_and4_sweep_checker;

  typedef struct {
    int   lat;
    int   err;
    logic fvalid;
    int   fev;
    logic pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  int   mode1 = 0;

  logic [3:0] data1, data2, fev1, fev2;
  logic       res1, res2, busy1, busy2, done1, done2, pass1, pass2, fval1, fval2;
  logic [7:0] err1;
  logic [1:0] err2;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // faulty tree models: 0 correct AND, 1 stuck-at-1, 2 OR, 3 inverted AND
  function automatic logic tree(input int m, input logic [3:0] v);
    case (m)
      1:       return 1'b1;
      2:       return |v;
      3:       return ~&v;
      default: return &v;
    endcase
  endfunction

  assign res1 = tree(mode1, data1);
  assign res2 = tree(3, data2);

  and4_sweep_checker u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_data(data1), .dut_result(res1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_valid(fval1), .first_err_vec(fev1)
  );

  and4_sweep_checker #(.WIDTH(4), .SETTLE(0), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_data(data2), .dut_result(res2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_err_valid(fval2), .first_err_vec(fev2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic sample(input int which, output logic [3:0] d, output logic bz, output logic dn,
                        output logic ps, output int er, output logic fv, output logic [3:0] fe);
    if (which == 0) begin
      d = data1; bz = busy1; dn = done1; ps = pass1; er = int'(err1); fv = fval1; fe = fev1;
    end else begin
      d = data2; bz = busy2; dn = done2; ps = pass2; er = int'(err2); fv = fval2; fe = fev2;
    end
  endtask

  task automatic drive_start(input int which, input logic v);
    if (which == 0) start1 = v;
    else            start2 = v;
  endtask

  task automatic run_sweep(input int which, input int m, input int repulse, input string nm);
    exp_t e, got_e;
    int settle, emax, cnt, first, n, done_n, ndone, er;
    logic [3:0] d, fe, prev;
    logic bz, dn, ps, fv, vec_ok, pulsed, busy_at_done, pass_after;
    settle = (which == 0) ? 1 : 0;
    emax   = (which == 0) ? 255 : 3;
    if (which == 0) mode1 = m;
    cnt = 0; first = -1;
    for (int v = 0; v < 16; v++) begin
      if (tree(m, 4'(v)) != (&4'(v))) begin
        cnt++;
        if (first < 0) first = v;
      end
    end
    e.lat    = 16 * (settle + 1);
    e.err    = (cnt > emax) ? emax : cnt;
    e.fvalid = (cnt > 0);
    e.fev    = (first < 0) ? 0 : first;
    e.pass   = (cnt == 0);
    sb.push_back(e);

    @(negedge clk); drive_start(which, 1'b1);
    @(negedge clk); drive_start(which, 1'b0);
    sample(which, d, bz, dn, ps, er, fv, fe);
    check({nm, "_busy_after_start"}, {31'd0, bz}, 32'd1);
    check({nm, "_first_vec"}, {28'd0, d}, 32'd0);

    n = 0; done_n = -1; ndone = 0; vec_ok = 1'b1; pulsed = 1'b0;
    prev = d; busy_at_done = 1'b1; pass_after = 1'b0;
    while (n < e.lat + 6) begin
      @(negedge clk);
      n++;
      drive_start(which, 1'b0);
      sample(which, d, bz, dn, ps, er, fv, fe);
      if (d != prev && d != prev + 4'd1) vec_ok = 1'b0;
      prev = d;
      if (repulse >= 0 && !pulsed && bz && int'(d) == repulse) begin
        drive_start(which, 1'b1);
        pulsed = 1'b1;
      end
      if (done_n >= 0 && n == done_n + 1) pass_after = ps;
      if (dn) begin
        ndone++;
        if (done_n < 0) begin
          done_n = n;
          busy_at_done = bz;
          got_e.err = er; got_e.fvalid = fv; got_e.fev = int'(fe);
        end
      end
    end

    if (sb.size() == 0) begin
      check({nm, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({nm, "_done_edge"}, done_n, e.lat);
      check({nm, "_done_count"}, ndone, 1);
      if (done_n >= 0) begin
        check({nm, "_err_count"}, got_e.err, e.err);
        check({nm, "_fvalid"}, {31'd0, got_e.fvalid}, {31'd0, e.fvalid});
        check({nm, "_fev"}, got_e.fev, e.fev);
        check({nm, "_busy_in_done"}, {31'd0, busy_at_done}, 32'd0);
        check({nm, "_pass"}, {31'd0, pass_after}, {31'd0, e.pass});
      end
      check({nm, "_vec_step"}, {31'd0, vec_ok}, 32'd1);
      check({nm, "_data_hold"}, {28'd0, d}, 32'd15);
      check({nm, "_err_hold"}, er, e.err);
    end
  endtask

  task automatic reset_mid_sweep();
    int n;
    mode1 = 0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    n = 0;
    while (data1 != 4'd7 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_vec7", {28'd0, data1}, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("rst_data", {28'd0, data1}, 32'd0);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_pass", {31'd0, pass1}, 32'd0);
    check("rst_err", {24'd0, err1}, 32'd0);
    check("rst_fvalid", {31'd0, fval1}, 32'd0);
    check("rst_fev", {28'd0, fev1}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_done", {31'd0, done1}, 32'd0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    check("init_data1", {28'd0, data1}, 32'd0);
    check("init_busy1", {31'd0, busy1}, 32'd0);
    check("init_done1", {31'd0, done1}, 32'd0);
    check("init_pass1", {31'd0, pass1}, 32'd0);
    check("init_err1", {24'd0, err1}, 32'd0);
    check("init_fval1", {31'd0, fval1}, 32'd0);
    check("init_err2", {30'd0, err2}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_sweep(0, 0, -1, "clean");
    run_sweep(0, 1, -1, "stuck1");
    run_sweep(0, 2, -1, "or_tree");
    run_sweep(0, 0, 5, "repulse");
    reset_mid_sweep();
    run_sweep(0, 0, -1, "after_rst");
    run_sweep(1, 3, -1, "sat_inv");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
